// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM address arbiter: state encoding, default sizes
// and the legal requester-count check.
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  localparam int ADDR_W_DEF  = 16;
  localparam int NUM_SRC_MIN = 2;
  localparam int NUM_SRC_MAX = 16;

  function automatic bit numSrcOk(input int n);
    return (n >= NUM_SRC_MIN) && (n <= NUM_SRC_MAX);
  endfunction

endpackage

// File: rtl/ram_address_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: picks the first set Req bit at or
// after Ptr (wrapping) and returns it one-hot; Ptr=0 gives plain lowest-index priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     Req,
  input  logic [PTR_W-1:0] Ptr,
  output logic [N-1:0]     Win,
  output logic             Any
);

  logic [N-1:0] reqRot;
  logic [N-1:0] winRot;

  // Rotate so Ptr lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    reqRot = N'({Req, Req} >> Ptr);
    winRot = reqRot & (~reqRot + N'(1));
    Win    = N'(({winRot, winRot} << Ptr) >> N);
    Any    = |Req;
  end

endmodule

// File: rtl/ram_address_arbiter.sv
// Registered request/grant arbiter driving the shared feature/weight RAM port.
// Define RAM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module ram_address_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SRC = 4
) (
  input  logic                      Clk,
  input  logic                      RstN,
  input  logic [NUM_SRC-1:0]        Req,
  input  logic [NUM_SRC-1:0]        Lock,
  input  logic [NUM_SRC*ADDR_W-1:0] AddrIn,
  input  logic [NUM_SRC-1:0]        WeIn,
  output logic [NUM_SRC-1:0]        Gnt,
  output logic [ADDR_W-1:0]         AddressToRAM,
  output logic                      WeToRAM,
  output logic                      RamValid,
  output logic                      Idle
);

  localparam int PTR_W = $clog2(NUM_SRC);

  if (!numSrcOk(NUM_SRC)) begin : gBadNumSrc
    $error("ram_address_arbiter: NUM_SRC=%0d outside legal range %0d..%0d",
           NUM_SRC, NUM_SRC_MIN, NUM_SRC_MAX);
  end

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic [PTR_W-1:0]     ptr;
  logic [NUM_SRC-1:0]   win;
  logic                 any;
  logic                 ownerHold;

  rr_pick #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) uPick (
    .Req (Req),
    .Ptr (ptr),
    .Win (win),
    .Any (any)
  );

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SRC - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] winIdx;
  logic [PTR_W-1:0] ptrNext;

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win[i]) winIdx = PTR_W'(i);
    end
    ptrNext = (winIdx == PTR_LAST) ? '0 : winIdx + PTR_W'(1);
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // An owner holding both Req and Lock skips arbitration entirely.
  assign ownerHold = |(gnt_q & Req & Lock);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    if (state_q == ST_IDLE) begin
      if (any) begin
        state_d = ST_OWNED;
        gnt_d   = win;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        ptr_d   = ptrNext;
`endif
      end else begin
        gnt_d = '0;
      end
    end else begin
      if (ownerHold) begin
        gnt_d = gnt_q;
      end else if (any) begin
        gnt_d = win;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        ptr_d = ptrNext;
`endif
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
  end

  // Muxing on the next grant keeps address and grant aligned on a switch.
  always_comb begin
    addr_d = '0;
    we_d   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_d[i]) begin
        addr_d = addr_d | AddrIn[i*ADDR_W +: ADDR_W];
        we_d   = we_d | WeIn[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign Gnt          = gnt_q;
  assign AddressToRAM = addr_q;
  assign WeToRAM      = we_q;
  assign RamValid     = |gnt_q;
  assign Idle         = (state_q == ST_IDLE);

endmodule

// File: doc/ram_address_arbiter.md
# ram_address_arbiter

Parametrised, registered arbiter that grants one of NUM_SRC address sources access to the shared feature/weight RAM and drives the RAM address and write-enable.
- Successor to the fixed 4-input, 16-bit RAM address mux: adds request/grant handshake, burst lock, optional round-robin fairness and registered outputs.
- Sits between the loader, decompressor, CNN layer engine and layer-input fetch units and the RAM port.

## Interface
Parameters:
- ADDR_W, 16, RAM address width in bits.
- NUM_SRC, 4, number of requesters (legal range 2..16); elaboration error outside the range.

Ports (clock and reset first):
- Clk  in  1  single clock; all state updates on the rising edge.
- RstN  in  1  reset, asynchronous and active-low.
- Req  in  NUM_SRC  per-source access request.
- Lock  in  NUM_SRC  per-source burst lock; keeps the grant while Req is also high. Lock without Req is ignored.
- AddrIn  in  NUM_SRC*ADDR_W  packed addresses; source i occupies [i*ADDR_W +: ADDR_W].
- WeIn  in  NUM_SRC  per-source write enable.
- Gnt  out  NUM_SRC  registered one-hot grant, or all zeros.
- AddressToRAM  out  ADDR_W  registered address of the granted source; 0 when nothing is granted.
- WeToRAM  out  1  registered WeIn of the granted source; 0 when nothing is granted.
- RamValid  out  1  equals |Gnt.
- Idle  out  1  high in state IDLE.

## Operation
- FSM has two states:
  - IDLE: no owner.
  - OWNED: one source holds Gnt.
- IDLE to OWNED: any Req bit high; the winner is picked by the arbitration rule.
- In OWNED, each cycle, in this order:
  - Owner Req high and owner Lock high: owner keeps the grant and no arbitration takes place.
  - Owner Req high and owner Lock low: re-arbitrate among all Req bits, owner included.
  - Owner Req low: re-arbitrate among the remaining requesters. If there are none, go to IDLE and clear Gnt, AddressToRAM and WeToRAM.
- Arbitration rule:
  - With round-robin (see Configuration): search begins at pointer Ptr and wraps modulo NUM_SRC.
  - Without round-robin: fixed priority, lowest index wins.
- Ptr updates to (winner+1) mod NUM_SRC on every arbitration cycle that produces a winner. Ptr is unchanged on lock-hold cycles and idle cycles.
- While a source is granted, AddressToRAM and WeToRAM follow that source's AddrIn and WeIn every cycle, with one cycle of latency.
- Simultaneous events:
  - A new Req arriving in the same cycle the owner drops is arbitrated normally.
  - A Lock rising in the same cycle as the grant decision applies from the following cycle.

## Timing
- Reset values: Gnt=0, AddressToRAM=0, WeToRAM=0, RamValid=0, Idle=1, state IDLE, Ptr=0. These apply immediately on RstN low, including mid-burst; no partial grant survives reset.
- Latency: Req/AddrIn/WeIn sampled at edge n produce Gnt/AddressToRAM/WeToRAM after edge n (visible in cycle n+1).
- Grant switch: the new owner's address appears in the same cycle as its Gnt bit; there is never a cycle where Gnt and AddressToRAM disagree.
- Release: owner Req low at edge n → outputs cleared (or the next owner installed) after edge n.
- Gnt is always one-hot or zero.
- No combinational path from inputs to outputs.

## Configuration
- Macro RAM_ARB_ROUND_ROBIN_EN.
- Defined: rotating-priority arbitration using Ptr as described; unlocked contending sources are served in turn.
- Undefined: fixed priority, lowest index wins. Ptr and its logic are not built. An unlocked index-0 requester starves all others, which matches the legacy mux priority order.

## Structure
- Shared package/include ram_arb_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_OWNED=1);
  - defaults ADDR_W_DEF=16 and NUM_SRC_MAX=16;
  - the NUM_SRC range check constant.
- One sub-module, rr_pick: combinational rotating-priority encoder (inputs Req and Ptr, outputs one-hot Win and Any).
  - Built as a double-width request vector shifted by Ptr.
  - When RAM_ARB_ROUND_ROBIN_EN is undefined it degenerates to Ptr=0.
- Top level holds the FSM, the Ptr register and the output registers/muxing.

## Test plan
Configuration for all scenarios: NUM_SRC=4, ADDR_W=16.
- Single request: Req=0010, AddrIn[1]=0x0003, WeIn=0010 → next cycle Gnt=0010, AddressToRAM=0x0003, WeToRAM=1, RamValid=1, Idle=0.
- Address tracking: owner 1 changes AddrIn[1] 0x0003→0x0009 → AddressToRAM=0x0009 exactly one cycle later; Gnt unchanged.
- Fairness: Req=1111, Lock=0 → with RAM_ARB_ROUND_ROBIN_EN, Gnt sequence 0001, 0010, 0100, 1000, 0001; without the macro, Gnt stays 0001.
- Lock: Req=0101, Lock=0001 for 5 cycles → Gnt=0001 for all 5; Lock drops → Gnt=0100 the next cycle (round-robin build).
- Release: all Req drop → next cycle Gnt=0000, AddressToRAM=0x0000, WeToRAM=0, RamValid=0, Idle=1.
- Reset mid-burst: RstN low while Gnt=0100, Lock=0100 → all outputs zero immediately; after release with Req=1111, the first Gnt is 0001 (Ptr reset to 0).
